instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter: RESET_PC, 64'h0000_0000_0000_0000, address of the first fetched instruction after reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 imem_req_valid  output  1  fetch request to instruction memory.
REQ-005 imem_req_ready  input  1  memory accepts request this cycle.
REQ-006 imem_addr  output  64  fetch address; equals internal pc.
REQ-007 imem_resp_valid  input  1  imem_rdata valid this cycle.
REQ-008 imem_rdata  input  32  fetched instruction word.
REQ-009 redirect_valid  input  1  branch/jump taken; replaces pc.
REQ-010 redirect_pc  input  64  target address (pc + sign-extended immediate, computed downstream).
REQ-011 inst_valid  output  1  instruction/inst_pc valid for the immediate decoder and decode stage.
REQ-012 inst_ready  input  1  decode stage consumes instruction this cycle.
REQ-013 instruction  output  32  registered instruction word.
REQ-014 inst_pc  output  64  address the instruction was fetched from.
REQ-015 misaligned_fault  output  1  sticky; redirect target not 4-byte aligned.

Function
REQ-016 States: IDLE, REQ, WAIT, HOLD, DRAIN, HALT; outputs decoded from registered state only (Moore).
REQ-017 imem_req_valid = 1 only in REQ; inst_valid = 1 only in HOLD; misaligned_fault = 1 only in HALT.
REQ-018 IDLE -> REQ unconditionally next cycle.
REQ-019 REQ: on imem_req_ready -> WAIT; else stay REQ with imem_addr held stable.
REQ-020 WAIT: on imem_resp_valid capture imem_rdata into instruction, pc into inst_pc, pc <= pc + 4, -> HOLD.
REQ-021 HOLD: instruction/inst_pc held stable; on inst_ready -> REQ.
REQ-022 At most one outstanding memory request; response arrives >= 1 cycle after request acceptance.
REQ-023 pc arithmetic is 64-bit modulo 2^64; pc + 4 from 64'hFFFF_FFFF_FFFF_FFFC wraps to 0 with no flag.
REQ-024 redirect_valid has priority over pc + 4 in every state; pc <= redirect_pc.
REQ-025 Redirect in IDLE or REQ without imem_req_ready: pc <= redirect_pc, -> REQ.
REQ-026 Redirect in REQ with imem_req_ready same cycle: -> DRAIN (stale request accepted).
REQ-027 Redirect in WAIT without imem_resp_valid: -> DRAIN; with imem_resp_valid same cycle: response discarded, -> REQ.
REQ-028 DRAIN: imem_req_valid = 0; on imem_resp_valid discard data, -> REQ; further redirects in DRAIN update pc only.
REQ-029 Redirect in HOLD (with or without inst_ready): instruction dropped, inst_valid = 0 next cycle, -> REQ.
REQ-030 redirect_pc[1:0] != 2'b00 with redirect_valid: -> HALT, pc unchanged; HALT left only by reset.
REQ-031 Minimum fetch period: 3 cycles per instruction (REQ, WAIT, HOLD) with zero-wait memory and inst_ready held high.

Reset
REQ-032 reset_n low asynchronously forces state IDLE, pc = RESET_PC, instruction = 32'h0000_0013 (nop), inst_pc = RESET_PC.
REQ-033 During reset: imem_req_valid = 0, inst_valid = 0, misaligned_fault = 0, imem_addr = RESET_PC.
REQ-034 Reset asserted mid-transaction (WAIT/DRAIN) abandons the outstanding request; a late response after reset release is ignored while in IDLE/REQ.

Verification
REQ-035 Reset release, memory always ready, 1-cycle response, inst_ready = 1 -> requests to 0x0, 0x4, 0x8 in that order; inst_valid every 3rd cycle with matching inst_pc.
REQ-036 HOLD with inst_ready = 0 for 5 cycles -> instruction/inst_pc stable, no new request; inst_ready = 1 -> REQ next cycle at inst_pc + 4.
REQ-037 redirect_valid = 1, redirect_pc = 0x100 in WAIT, response 2 cycles later -> response discarded, next request address 0x100, no inst_valid for the stale word.
REQ-038 redirect_pc = 0x102 -> misaligned_fault = 1 next cycle, imem_req_valid stays 0 until reset_n pulsed low.
REQ-039 pc = 0xFFFF_FFFF_FFFF_FFFC fetched -> next request address 0x0.
REQ-040 reset_n asserted in WAIT, response arrives after release -> outputs at reset values, first request to RESET_PC, stale word never presented.

Source files
------------

// File: rtl/instruction_fetch.sv
// Single-outstanding instruction fetch: REQ -> WAIT -> HOLD loop with redirect squash and misaligned-target halt.
// Latency: 3 cycles per instruction minimum; backpressure via imem_req_ready (REQ) and inst_ready (HOLD).
module instruction_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] instruction,
  output logic [63:0] inst_pc,
  output logic        misaligned_fault
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    DRAIN = 3'd4,
    HALT  = 3'd5
  } state_t;

  state_t      state;
  logic [63:0] pc;
  logic        redir_ok;
  logic        redir_bad;

  assign redir_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign redir_ok  = redirect_valid && (redirect_pc[1:0] == 2'b00);

  assign imem_req_valid   = (state == REQ);
  assign inst_valid       = (state == HOLD);
  assign misaligned_fault = (state == HALT);
  assign imem_addr        = pc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instruction <= 32'h0000_0013;
      inst_pc     <= RESET_PC;
    end else if (state != HALT) begin
      if (redir_bad) begin
        state <= HALT;
      end else begin
        if (redir_ok) pc <= redirect_pc;
        case (state)
          IDLE: state <= REQ;
          REQ: begin
            // A request accepted in the redirect cycle is stale; its response must be drained.
            if (imem_req_ready) state <= redir_ok ? DRAIN : WAIT;
          end
          WAIT: begin
            if (imem_resp_valid) begin
              if (redir_ok) begin
                state <= REQ;
              end else begin
                instruction <= imem_rdata;
                inst_pc     <= pc;
                pc          <= pc + 64'd4;
                state       <= HOLD;
              end
            end else if (redir_ok) begin
              state <= DRAIN;
            end
          end
          HOLD: begin
            if (inst_ready || redir_ok) state <= REQ;
          end
          DRAIN: begin
            if (imem_resp_valid) state <= REQ;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios then random traffic against a transaction-level model.
module tb_instruction_fetch;

  localparam logic [63:0] RST = 64'h0;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [63:0] imem_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = 64'h0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] instruction;
  logic [63:0] inst_pc;
  logic        misaligned_fault;

  always #5 clk = ~clk;

  instruction_fetch #(.RESET_PC(RST)) dut (
    .clk(clk), .reset_n(reset_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_resp_valid(imem_resp_valid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .instruction(instruction), .inst_pc(inst_pc), .misaligned_fault(misaligned_fault)
  );

  int checks = 0;
  int failures = 0;

  // Transaction-level view: next fetch address, one outstanding request, one presented word.
  logic [63:0] m_pc, m_req_addr, m_ipc;
  logic [31:0] m_inst;
  bit m_fresh, m_out, m_squash, m_present, m_halt;

  bit drv_pend;
  int drv_cnt;
  int dly_lo = 0;
  int dly_hi = 0;
  logic [63:0] acc_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_req();
    return !m_fresh && !m_halt && !m_out && !m_present;
  endfunction

  task automatic model_reset();
    m_pc = RST; m_req_addr = RST; m_ipc = RST; m_inst = 32'h13;
    m_fresh = 1; m_out = 0; m_squash = 0; m_present = 0; m_halt = 0;
  endtask

  task automatic check_outputs();
    chk("req_valid", 64'(imem_req_valid), 64'(exp_req()));
    chk("inst_valid", 64'(inst_valid), 64'(m_present && !m_halt));
    chk("fault", 64'(misaligned_fault), 64'(m_halt));
    chk("imem_addr", imem_addr, m_pc);
    if (m_present && !m_halt) begin
      chk("instruction", 64'(instruction), 64'(m_inst));
      chk("inst_pc", inst_pc, m_ipc);
    end
  endtask

  task automatic model_update();
    bit accept, hit;
    accept = exp_req() && imem_req_ready;
    hit = m_out && imem_resp_valid;
    if (drv_pend) begin
      if (imem_resp_valid) drv_pend = 0;
      else drv_cnt--;
    end
    if (accept) begin
      drv_pend = 1;
      drv_cnt = $urandom_range(dly_hi, dly_lo);
      acc_q.push_back(m_pc);
    end
    if (m_halt) return;
    if (redirect_valid && redirect_pc[1:0] != 2'b00) begin
      m_halt = 1;
      return;
    end
    if (m_present && (inst_ready || redirect_valid)) m_present = 0;
    if (accept) begin
      m_out = 1; m_squash = redirect_valid; m_req_addr = m_pc;
    end else if (hit) begin
      m_out = 0;
      if (!m_squash && !redirect_valid) begin
        m_present = 1; m_inst = imem_rdata; m_ipc = m_req_addr; m_pc = m_req_addr + 64'd4;
      end
    end else if (m_out && redirect_valid) begin
      m_squash = 1;
    end
    if (redirect_valid) m_pc = redirect_pc;
    m_fresh = 0;
  endtask

  // Called at a falling edge; leaves the bench at the next falling edge.
  task automatic tick(input bit red, input logic [63:0] rpc, input bit rdy, input bit irdy);
    check_outputs();
    redirect_valid  = red;
    redirect_pc     = rpc;
    imem_req_ready  = rdy;
    inst_ready      = irdy;
    imem_resp_valid = drv_pend && (drv_cnt == 0);
    imem_rdata      = $urandom;
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic do_reset(input bit keep_stale);
    reset_n = 1'b0;
    redirect_valid = 1'b0; imem_req_ready = 1'b0; inst_ready = 1'b0; imem_resp_valid = 1'b0;
    #1;
    chk("rst_req_valid", 64'(imem_req_valid), 64'h0);
    chk("rst_inst_valid", 64'(inst_valid), 64'h0);
    chk("rst_fault", 64'(misaligned_fault), 64'h0);
    chk("rst_imem_addr", imem_addr, RST);
    chk("rst_instruction", 64'(instruction), 64'h13);
    chk("rst_inst_pc", inst_pc, RST);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    if (keep_stale && drv_pend) drv_cnt = 0;
    else drv_pend = 0;
  endtask

  initial begin
    logic [63:0] rpc;
    bit red;
    @(negedge clk);
    do_reset(0);

    // Back-to-back fetch, zero-wait memory.
    acc_q.delete();
    for (int i = 0; i < 9; i++) tick(0, 64'h0, 1, 1);
    chk("seq_count", 64'(acc_q.size()), 64'd3);
    if (acc_q.size() == 3) begin
      chk("seq_addr0", acc_q[0], 64'h0);
      chk("seq_addr1", acc_q[1], 64'h4);
      chk("seq_addr2", acc_q[2], 64'h8);
    end

    // Decode stall in HOLD, then release.
    for (int i = 0; i < 5; i++) tick(0, 64'h0, 1, 0);
    tick(0, 64'h0, 1, 1);
    chk("hold_next_req", 64'(imem_req_valid), 64'h1);
    chk("hold_next_addr", imem_addr, 64'hC);

    // Redirect while waiting; response lands afterwards and is discarded.
    dly_lo = 1; dly_hi = 1;
    tick(0, 64'h0, 1, 1);
    tick(1, 64'h100, 1, 1);
    dly_lo = 0; dly_hi = 0;
    tick(0, 64'h0, 1, 1);
    chk("redir_req", 64'(imem_req_valid), 64'h1);
    chk("redir_addr", imem_addr, 64'h100);
    for (int i = 0; i < 3; i++) tick(0, 64'h0, 1, 1);

    // Top-of-address-space wrap.
    acc_q.delete();
    tick(1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 1);
    for (int i = 0; i < 4; i++) tick(0, 64'h0, 1, 1);
    chk("wrap_count", 64'(acc_q.size()), 64'd2);
    if (acc_q.size() == 2) begin
      chk("wrap_addr0", acc_q[0], 64'hFFFF_FFFF_FFFF_FFFC);
      chk("wrap_addr1", acc_q[1], 64'h0);
    end

    // Misaligned target halts until reset.
    tick(1, 64'h102, 1, 1);
    chk("mis_fault", 64'(misaligned_fault), 64'h1);
    for (int i = 0; i < 5; i++) tick($urandom_range(0, 1) == 1, 64'h200, 1, 1);
    chk("mis_still_halted", 64'(imem_req_valid), 64'h0);
    do_reset(0);

    // Reset during WAIT with the response arriving after release.
    dly_lo = 2; dly_hi = 2;
    tick(0, 64'h0, 1, 1);
    tick(0, 64'h0, 1, 1);
    dly_lo = 0; dly_hi = 0;
    do_reset(1);
    acc_q.delete();
    for (int i = 0; i < 4; i++) tick(0, 64'h0, 1, 0);
    chk("post_rst_first_addr", (acc_q.size() > 0) ? acc_q[0] : 64'hDEAD, RST);

    // Random traffic.
    dly_lo = 0; dly_hi = 3;
    for (int i = 0; i < 3000; i++) begin
      red = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 2))
        0: rpc = {$urandom, $urandom} & ~64'h3;
        1: rpc = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 3) * 4);
        default: rpc = 64'($urandom_range(0, 255) * 4);
      endcase
      if ($urandom_range(0, 60) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
      tick(red, rpc, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
      if (m_halt && $urandom_range(0, 4) == 0) do_reset($urandom_range(0, 1) == 1);
      else if ($urandom_range(0, 400) == 0) do_reset(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
